// File: rtl/regfile_pkg.sv
// Shared types and defaults for the RegFile command-side master.
package regfile_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam logic [31:0] INIT_VAL_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StWr,
        StRd,
        StResp
    } state_e;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sweep: walks addresses 0..DEPTH-1 once and flags completion.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    // One extra bit so the counter can park at DEPTH after the last write.
    logic [ADDR_W:0] cnt_q;

    assign addr = cnt_q[ADDR_W-1:0];
    assign done = (cnt_q == (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Command-side RegFile master: clears the RegFile after reset, then serves
// single-outstanding reads and pipelined writes over valid/ready ports.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       DEPTH    = DEPTH_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_VAL_DEF)
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_ra1,
    input  logic [ADDR_W-1:0] cmd_ra2,
    input  logic [ADDR_W-1:0] cmd_wa,
    input  logic [DATA_W-1:0] cmd_wd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rd1,
    output logic [DATA_W-1:0] rsp_rd2,
    output logic [ADDR_W-1:0] rf_RA1,
    output logic [ADDR_W-1:0] rf_RA2,
    output logic [ADDR_W-1:0] rf_WA,
    output logic [DATA_W-1:0] rf_WD,
    output logic              rf_WE1,
    input  logic [DATA_W-1:0] rf_RD1,
    input  logic [DATA_W-1:0] rf_RD2
);

    state_e state_q, state_d;

    logic              init_done_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rd1_d, rsp_rd2_d;
    logic [ADDR_W-1:0] ra1_d, ra2_d, wa_d;
    logic [DATA_W-1:0] wd_d;
    logic              we_d;
    logic              ra1_oob_q, ra1_oob_d;
    logic              ra2_oob_q, ra2_oob_d;

    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_done;

    regfile_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state_q == StInit),
        .addr (sweep_addr),
        .done (sweep_done)
    );

    assign cmd_ready = (state_q == StIdle) || (state_q == StWr);

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done;
        rsp_valid_d = rsp_valid;
        rsp_rd1_d   = rsp_rd1;
        rsp_rd2_d   = rsp_rd2;
        ra1_d       = rf_RA1;
        ra2_d       = rf_RA2;
        wa_d        = rf_WA;
        wd_d        = rf_WD;
        we_d        = 1'b0;
        ra1_oob_d   = ra1_oob_q;
        ra2_oob_d   = ra2_oob_q;

        unique case (state_q)
            StInit: begin
                if (sweep_done) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    we_d = 1'b1;
                    wa_d = sweep_addr;
                    wd_d = INIT_VAL;
                end
            end
            StIdle, StWr: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        // Out-of-range writes are acknowledged but never strobe WE1.
                        state_d = StWr;
                        we_d    = addr_in_range(32'(cmd_wa), DEPTH);
                        wa_d    = cmd_wa;
                        wd_d    = cmd_wd;
                    end else begin
                        state_d   = StRd;
                        ra1_d     = cmd_ra1;
                        ra2_d     = cmd_ra2;
                        ra1_oob_d = !addr_in_range(32'(cmd_ra1), DEPTH);
                        ra2_oob_d = !addr_in_range(32'(cmd_ra2), DEPTH);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                rsp_rd1_d   = ra1_oob_q ? '0 : rf_RD1;
                rsp_rd2_d   = ra2_oob_q ? '0 : rf_RD2;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StInit;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rd1   <= '0;
            rsp_rd2   <= '0;
            rf_RA1    <= '0;
            rf_RA2    <= '0;
            rf_WA     <= '0;
            rf_WD     <= '0;
            rf_WE1    <= 1'b0;
            ra1_oob_q <= 1'b0;
            ra2_oob_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_done <= init_done_d;
            rsp_valid <= rsp_valid_d;
            rsp_rd1   <= rsp_rd1_d;
            rsp_rd2   <= rsp_rd2_d;
            rf_RA1    <= ra1_d;
            rf_RA2    <= ra2_d;
            rf_WA     <= wa_d;
            rf_WD     <= wd_d;
            rf_WE1    <= we_d;
            ra1_oob_q <= ra1_oob_d;
            ra2_oob_q <= ra2_oob_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural RegFile attached.
module tb_regfile_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        init_done;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_ra1, cmd_ra2, cmd_wa;
    logic [31:0] cmd_wd;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rd1, rsp_rd2;
    logic [5:0]  rf_RA1, rf_RA2, rf_WA;
    logic [31:0] rf_WD;
    logic        rf_WE1;
    logic [31:0] rf_RD1, rf_RD2;

    logic [31:0] mem [64];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // RegFile model: synchronous write, asynchronous read; preload seeds non-zero garbage.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (rf_WE1) begin
            mem[rf_WA] <= rf_WD;
        end
    end
    assign rf_RD1 = mem[rf_RA1];
    assign rf_RD2 = mem[rf_RA2];

    regfile_access_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_ra1   (cmd_ra1),
        .cmd_ra2   (cmd_ra2),
        .cmd_wa    (cmd_wa),
        .cmd_wd    (cmd_wd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rd1   (rsp_rd1),
        .rsp_rd2   (rsp_rd2),
        .rf_RA1    (rf_RA1),
        .rf_RA2    (rf_RA2),
        .rf_WA     (rf_WA),
        .rf_WD     (rf_WD),
        .rf_WE1    (rf_WE1),
        .rf_RD1    (rf_RD1),
        .rf_RD2    (rf_RD2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int waits = 0;
        while (!cmd_ready && waits < 50) begin
            tick();
            waits++;
        end
        check({nm, " cmd_ready before issue"}, 32'(cmd_ready), 1);
    endtask

    task automatic do_write(input logic [5:0] wa, input logic [31:0] wd, input string nm);
        wait_ready(nm);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wa = wa; cmd_wd = wd;
        tick();
        cmd_valid = 1'b0;
        check({nm, " WE1 in WR"}, 32'(rf_WE1), 1);
        check({nm, " WA"}, 32'(rf_WA), 32'(wa));
        check({nm, " WD"}, rf_WD, wd);
        tick();
        check({nm, " WE1 back to 0"}, 32'(rf_WE1), 0);
    endtask

    task automatic do_read(input logic [5:0] a1, input logic [5:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2, input string nm);
        wait_ready(nm);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_ra1 = a1; cmd_ra2 = a2;
        tick();
        cmd_valid = 1'b0;
        check({nm, " rsp_valid after 1 edge"}, 32'(rsp_valid), 0);
        check({nm, " cmd_ready in RD"}, 32'(cmd_ready), 0);
        tick();
        check({nm, " rsp_valid after 2 edges"}, 32'(rsp_valid), 1);
        check({nm, " rsp_rd1"}, rsp_rd1, e1);
        check({nm, " rsp_rd2"}, rsp_rd2, e2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({nm, " rsp_valid cleared"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int we_cnt;
        int waits;

        RST = 1'b1; preload = 1'b1; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wa = 6'd5; cmd_wd = 32'h1234_5678;
        cmd_ra1 = '0; cmd_ra2 = '0;
        tick();
        RST = 1'b0; preload = 1'b0;

        // 1: reset state and clear sweep, with cmd_valid held high throughout
        check("rst WE1", 32'(rf_WE1), 0);
        check("rst init_done", 32'(init_done), 0);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_rd1", rsp_rd1, 0);
        check("rst WA", 32'(rf_WA), 0);
        check("rst cmd_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 64; i++) begin
            tick();
            check($sformatf("sweep%0d WE1", i), 32'(rf_WE1), 1);
            check($sformatf("sweep%0d WA", i), 32'(rf_WA), 32'(i));
            check($sformatf("sweep%0d WD", i), rf_WD, 0);
            check($sformatf("sweep%0d cmd_ready", i), 32'(cmd_ready), 0);
            check($sformatf("sweep%0d init_done", i), 32'(init_done), 0);
        end
        tick();
        cmd_valid = 1'b0;
        check("post-sweep init_done", 32'(init_done), 1);
        check("post-sweep WE1", 32'(rf_WE1), 0);
        check("post-sweep cmd_ready", 32'(cmd_ready), 1);
        check("cleared mem[0]", mem[0], 0);
        check("cleared mem[5]", mem[5], 0);
        check("cleared mem[63]", mem[63], 0);

        // 2: write then read back
        do_write(6'd5, 32'hDEAD_BEEF, "t2 wr");
        do_read(6'd5, 6'd0, 32'hDEAD_BEEF, 32'h0, "t2 rd");

        // 3: read accepted in WR sees the write committing at the same edge
        wait_ready("t3");
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wa = 6'd7; cmd_wd = 32'd9;
        tick();
        check("t3 WE1", 32'(rf_WE1), 1);
        check("t3 cmd_ready in WR", 32'(cmd_ready), 1);
        cmd_write = 1'b0; cmd_ra1 = 6'd7; cmd_ra2 = 6'd5;
        tick();
        cmd_valid = 1'b0;
        check("t3 WE1 in RD", 32'(rf_WE1), 0);
        tick();
        check("t3 rsp_valid", 32'(rsp_valid), 1);
        check("t3 rsp_rd1", rsp_rd1, 32'd9);
        check("t3 rsp_rd2", rsp_rd2, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 4: response stall holds data and blocks commands
        wait_ready("t4");
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_ra1 = 6'd5; cmd_ra2 = 6'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4 stall%0d rsp_valid", i), 32'(rsp_valid), 1);
            check($sformatf("t4 stall%0d rd1", i), rsp_rd1, 32'hDEAD_BEEF);
            check($sformatf("t4 stall%0d rd2", i), rsp_rd2, 32'd9);
            check($sformatf("t4 stall%0d cmd_ready", i), 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4 rsp_valid cleared", 32'(rsp_valid), 0);
        check("t4 cmd_ready back", 32'(cmd_ready), 1);

        // 5: reset during RESP drops the response and reruns the sweep
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_ra1 = 6'd5; cmd_ra2 = 6'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5 in RESP", 32'(rsp_valid), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5 rsp_valid dropped", 32'(rsp_valid), 0);
        check("t5 rsp_rd1 reset", rsp_rd1, 0);
        check("t5 init_done reset", 32'(init_done), 0);
        check("t5 cmd_ready", 32'(cmd_ready), 0);
        we_cnt = 0;
        waits = 0;
        while (!init_done && waits < 200) begin
            tick();
            if (rf_WE1) we_cnt++;
            waits++;
        end
        check("t5 init_done again", 32'(init_done), 1);
        check("t5 sweep write count", 32'(we_cnt), 64);
        do_read(6'd5, 6'd7, 32'h0, 32'h0, "t5 rd");

        // 6: four back-to-back writes, then paired readback
        wait_ready("t6");
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wa = 6'd0; cmd_wd = 32'd10;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6 b2b%0d WE1", i), 32'(rf_WE1), 1);
            check($sformatf("t6 b2b%0d WA", i), 32'(rf_WA), 32'(i));
            check($sformatf("t6 b2b%0d WD", i), rf_WD, 32'(10 + i));
            if (i < 3) begin
                cmd_wa = 6'(i + 1);
                cmd_wd = 32'(11 + i);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        check("t6 WE1 after burst", 32'(rf_WE1), 0);
        do_read(6'd0, 6'd1, 32'd10, 32'd11, "t6 rd01");
        do_read(6'd2, 6'd3, 32'd12, 32'd13, "t6 rd23");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
